// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command sequencer in front of the 20-bit ALU datapath
// Executes program-flow ops locally, forwards ALU ops and owns the {carry,sign,zero} status.
module alu_sequencer #(
    parameter int WIDTH = 20,
    parameter int HALF  = 10,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic             cmd_mode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [OP_W-1:0]  alu_op_o,
    output logic             alu_mode_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic             alu_cin_o,
    input  logic [WIDTH-1:0] alu_res_i,
    input  logic [WIDTH-1:0] alu_res2_i,
    input  logic             alu_zero_i,
    input  logic             alu_sign_i,
    input  logic             alu_carry_i,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_last,
    output logic             rsp_taken,
    output logic [2:0]       status_o,
    output logic             busy,
    output logic             trap
);

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_JMP  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JZ   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JS   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JZS  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LSR  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_XSR  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SWAP = OP_W'(16);
    localparam logic [OP_W-1:0] OP_ADC  = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SBC  = OP_W'(22);
    localparam logic [OP_W-1:0] OP_LE   = OP_W'(27);
    localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};

    typedef enum logic [2:0] {IDLE, EXEC, RESP, RESP2, TRAPPED} state_t;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic             alu_mode_q, alu_mode_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] res2_q, res2_d;
    logic             taken_q, taken_d;
    logic [2:0]       status_q, status_d;
    logic             trap_q, trap_d;
    logic [WIDTH-1:0] opnd_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            alu_op_q   <= '0;
            alu_mode_q <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            data_q     <= '0;
            res2_q     <= '0;
            taken_q    <= 1'b0;
            status_q   <= 3'b000;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            alu_op_q   <= alu_op_d;
            alu_mode_q <= alu_mode_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            data_q     <= data_d;
            res2_q     <= res2_d;
            taken_q    <= taken_d;
            status_q   <= status_d;
            trap_q     <= trap_d;
        end
    end

    assign opnd_mask = cmd_mode ? {WIDTH{1'b1}} : HALF_MASK;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        alu_op_d   = alu_op_q;
        alu_mode_d = alu_mode_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        data_d     = data_q;
        res2_d     = res2_q;
        taken_d    = taken_q;
        status_d   = status_q;
        trap_d     = trap_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    if (cmd_op >= OP_NOT && cmd_op <= OP_LE) begin
                        state_d    = EXEC;
                        alu_op_d   = cmd_op;
                        alu_mode_d = cmd_mode;
                        alu_a_d    = cmd_a & opnd_mask;
                        alu_b_d    = cmd_b & opnd_mask;
                        alu_cin_d  = (cmd_op == OP_ADC || cmd_op == OP_SBC) && status_q[2];
                    end else if (cmd_op >= OP_NOP && cmd_op <= OP_XSR) begin
                        // Jump conditions use the status as it stands at accept time.
                        state_d = RESP;
                        data_d  = cmd_a;
                        taken_d = 1'b0;
                        case (cmd_op)
                            OP_NOP: data_d = '0;
                            OP_JMP: taken_d = 1'b1;
                            OP_JZ:  taken_d = status_q[0];
                            OP_JS:  taken_d = status_q[1];
                            OP_JZS: taken_d = status_q[0] | status_q[1];
                            OP_LSR: begin
                                status_d = cmd_a[2:0];
                                data_d   = {{(WIDTH-3){1'b0}}, cmd_a[2:0]};
                            end
                            OP_XSR: begin
                                status_d = status_q ^ cmd_a[2:0];
                                data_d   = {{(WIDTH-3){1'b0}}, status_q ^ cmd_a[2:0]};
                            end
                            default: ;
                        endcase
                    end else begin
                        state_d = TRAPPED;
                        trap_d  = 1'b1;
                    end
                end
            end
            EXEC: begin
                data_d   = alu_res_i;
                res2_d   = alu_res2_i;
                taken_d  = 1'b0;
                status_d = {alu_carry_i, alu_sign_i, alu_zero_i};
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = (op_q == OP_SWAP) ? RESP2 : IDLE;
            end
            RESP2: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: ;
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign trap       = trap_q;
    assign status_o   = status_q;
    assign alu_op_o   = alu_op_q;
    assign alu_mode_o = alu_mode_q;
    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_cin_o  = alu_cin_q;
    assign rsp_valid  = (state_q == RESP) || (state_q == RESP2);
    assign rsp_data   = (state_q == RESP) ? data_q : (state_q == RESP2) ? res2_q : '0;
    assign rsp_last   = (state_q == RESP) ? (op_q != OP_SWAP) : (state_q == RESP2);
    assign rsp_taken  = (state_q == RESP) && taken_q;

endmodule
